// File: rtl/radio_link_pkg.sv
// Shared frame definitions for the radio link serializer and deserializer.
// A frame is 8 bits sent MSB-first: R0_I, R0_Q, R1_I, R1_Q, two bits each.
package radio_link_pkg;

   localparam int FRAME_BITS = 8;
   localparam int CNT_W      = 3;
   localparam int FIELD_W    = 2;

   // LSB position of each field inside the assembled frame word
   localparam int R0_I_LSB = 6;
   localparam int R0_Q_LSB = 4;
   localparam int R1_I_LSB = 2;
   localparam int R1_Q_LSB = 0;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

endpackage

// File: rtl/radio_frame_shifter.sv
// Serial-to-parallel shifter with frame bit counter.
// The frame output includes the bit currently on the data input.
module radio_frame_shifter
   import radio_link_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  data,
   input  logic                  load_bit0,
   input  logic                  shift,
   output logic [CNT_W-1:0]      count,
   output logic [FRAME_BITS-1:0] frame
);

   logic [FRAME_BITS-2:0] shreg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load_bit0) begin
         count <= CNT_W'(1);
      end else if (shift) begin
         count <= count + CNT_W'(1);
      end
   end

   // Data path needs no reset: only complete frames are ever emitted
   always_ff @(posedge clk) begin
      if (load_bit0 || shift) begin
         shreg <= {shreg[FRAME_BITS-3:0], data};
      end
   end

   assign frame = {shreg, data};

endmodule

// File: rtl/radio_frame_deser.sv
// Radio frame deserializer: acquires frame alignment from SYNC_IN and
// emits the four recovered sample fields with a one-cycle VALID strobe.
module radio_frame_deser
   import radio_link_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int ERR_W      = 8
)
(
   input  logic             SYS_CLK,
   input  logic             RST,
   input  logic             DATA_IN,
   input  logic             SYNC_IN,
   output logic [1:0]       R0_I,
   output logic [1:0]       R0_Q,
   output logic [1:0]       R1_I,
   output logic [1:0]       R1_Q,
   output logic             VALID,
   output logic             LOCK,
   output logic [ERR_W-1:0] ERR_COUNT
);

   state_t                  state;
   state_t                  state_nxt;
   logic [CNT_W-1:0]        count;
   logic [FRAME_BITS-1:0]   frame;
   logic [3:0]              good;
   logic                    good_hit;
   logic                    cnt_zero;
   logic                    cnt_last;
   logic                    load_bit0;
   logic                    shift;
   logic                    good_clr;
   logic                    good_inc;
   logic                    err_inc;
   logic                    emit;

   radio_frame_shifter u_shifter (
      .clk       (SYS_CLK),
      .rst       (RST),
      .data      (DATA_IN),
      .load_bit0 (load_bit0),
      .shift     (shift),
      .count     (count),
      .frame     (frame)
   );

   assign cnt_zero = (count == '0);
   assign cnt_last = (count == CNT_W'(FRAME_BITS - 1));
   assign good_hit = (({1'b0, good} + 5'd1) == 5'(LOCK_COUNT));

   always_ff @(posedge SYS_CLK) begin
      if (RST) begin
         state <= HUNT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         HUNT: begin
            if (SYNC_IN) state_nxt = VERIFY;
         end
         VERIFY: begin
            if (cnt_zero) begin
               if (!SYNC_IN)      state_nxt = HUNT;
               else if (good_hit) state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            if (cnt_zero) begin
               if (!SYNC_IN) state_nxt = HUNT;
            end else if (SYNC_IN) begin
               state_nxt = VERIFY;
            end
         end
         default: state_nxt = HUNT;
      endcase
   end

   // A misplaced SYNC restarts alignment with that bit as the new bit 0
   always_comb begin
      load_bit0 = 1'b0;
      shift     = 1'b0;
      good_clr  = 1'b0;
      good_inc  = 1'b0;
      err_inc   = 1'b0;
      emit      = 1'b0;
      unique case (state)
         HUNT: begin
            load_bit0 = SYNC_IN;
            good_clr  = SYNC_IN;
         end
         VERIFY: begin
            if (cnt_zero) begin
               shift    = SYNC_IN;
               good_inc = SYNC_IN;
            end else if (SYNC_IN) begin
               load_bit0 = 1'b1;
               good_clr  = 1'b1;
            end else begin
               shift = 1'b1;
            end
         end
         LOCKED: begin
            if (cnt_zero) begin
               shift   = SYNC_IN;
               err_inc = !SYNC_IN;
            end else if (SYNC_IN) begin
               err_inc   = 1'b1;
               load_bit0 = 1'b1;
               good_clr  = 1'b1;
            end else begin
               shift = 1'b1;
               emit  = cnt_last;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge SYS_CLK) begin
      if (RST || good_clr) begin
         good <= '0;
      end else if (good_inc) begin
         good <= good + 4'd1;
      end
   end

   always_ff @(posedge SYS_CLK) begin
      if (RST) begin
         ERR_COUNT <= '0;
      end else if (err_inc && (ERR_COUNT != {ERR_W{1'b1}})) begin
         ERR_COUNT <= ERR_COUNT + ERR_W'(1);
      end
   end

   always_ff @(posedge SYS_CLK) begin
      if (RST) begin
         R0_I  <= '0;
         R0_Q  <= '0;
         R1_I  <= '0;
         R1_Q  <= '0;
         VALID <= 1'b0;
         LOCK  <= 1'b0;
      end else begin
         VALID <= emit;
         LOCK  <= (state_nxt == LOCKED);
         if (emit) begin
            R0_I <= frame[R0_I_LSB +: FIELD_W];
            R0_Q <= frame[R0_Q_LSB +: FIELD_W];
            R1_I <= frame[R1_I_LSB +: FIELD_W];
            R1_Q <= frame[R1_Q_LSB +: FIELD_W];
         end
      end
   end

endmodule

// File: doc/radio_frame_deser.md
Name: radio_frame_deser

Overview:
- Receive-side stage directly downstream of radio_module.
- Consumes the serial DATA_OUT/SYNC stream and recovers the four 2-bit sample fields R0_I, R0_Q, R1_I, R1_Q, one set per frame.
- Acquires frame alignment with a HUNT/VERIFY/LOCKED state machine and counts alignment errors.
- Feeds the correlator/capture logic with a one-cycle VALID strobe per recovered frame.

Parameters:
- LOCK_COUNT, 4: consecutive correctly-placed SYNC frames required in VERIFY before entering LOCKED (range 1..15).
- ERR_W, 8: width of the saturating alignment-error counter.

Ports:
- SYS_CLK  in  1  system clock; the serial stream is synchronous to it, one bit per cycle.
- RST  in  1  synchronous reset, active-high.
- DATA_IN  in  1  serial frame data (DATA_OUT of radio_module).
- SYNC_IN  in  1  high during bit 0 of each frame (SYNC of radio_module).
- R0_I  out  2  recovered radio 0 in-phase sample.
- R0_Q  out  2  recovered radio 0 quadrature sample.
- R1_I  out  2  recovered radio 1 in-phase sample.
- R1_Q  out  2  recovered radio 1 quadrature sample.
- VALID  out  1  one-cycle strobe: sample outputs updated this cycle.
- LOCK  out  1  high while the state machine is in LOCKED.
- ERR_COUNT  out  ERR_W  saturating count of alignment errors seen while LOCKED.

Behaviour:
- One clock (SYS_CLK); reset is synchronous and active-high (RST).
- Reset: state HUNT; bit counter 0; good-frame counter 0.
- Reset: R0_I, R0_Q, R1_I, R1_Q = 0; VALID = 0; LOCK = 0; ERR_COUNT = 0.
- Reset mid-frame discards the partial frame. No VALID until lock is reacquired.
- Frame: FRAME_BITS = 8, MSB-first. Bit order is R0_I[1], R0_I[0], R0_Q[1], R0_Q[0], R1_I[1], R1_I[0], R1_Q[1], R1_Q[0].
- DATA_IN and SYNC_IN are sampled on every rising edge.
- Bit counter runs 0..7 and wraps from 7 to 0. A "correct" SYNC is SYNC_IN=1 when the counter is 0.
- HUNT:
  - SYNC_IN=0: stay in HUNT; data ignored.
  - SYNC_IN=1: take the bit as bit 0; counter <= 1; good <= 0; go to VERIFY.
- VERIFY, counter=0:
  - SYNC_IN=1: good <= good+1. If good+1 == LOCK_COUNT, go to LOCKED; the frame starting at this bit is the first one emitted.
  - SYNC_IN=0: go to HUNT.
- VERIFY, counter!=0, SYNC_IN=1 (misplaced SYNC): take the bit as a new bit 0; counter <= 1; good <= 0; stay in VERIFY.
- LOCKED, counter=0, SYNC_IN=0: ERR_COUNT++ (saturating); go to HUNT; partial frame discarded.
- LOCKED, counter!=0, SYNC_IN=1: ERR_COUNT++ (saturating); go to VERIFY with good=0; the bit becomes bit 0; partial frame discarded.
- Emission (LOCKED only):
  - On the edge that samples bit 7, the four sample outputs load from {shift[6:0], DATA_IN}.
  - VALID=1 for exactly the following cycle.
  - Latency: outputs valid 1 cycle after bit 7 is on DATA_IN.
  - Back-to-back frames give one VALID every 8 cycles.
- Sample outputs hold their last value between strobes and across loss of lock.
- VALID is never asserted for a frame that was not entirely received while LOCKED.
- LOCK is registered and equals (state == LOCKED).
- ERR_COUNT saturates at 2^ERR_W-1 and clears only on RST.
- In the same cycle, RST takes priority over all other events.

Decomposition:
- Package radio_link_pkg:
  - FRAME_BITS = 8 and the bit-counter width (3).
  - State encoding HUNT / VERIFY / LOCKED.
  - Field bit-position constants, shared with radio_module's serializer so the bit order has a single definition.
- Sub-module radio_frame_shifter:
  - 8-bit shift register plus 3-bit bit counter.
  - Inputs: load_bit0, shift.
  - Outputs: counter value and assembled frame word.
- The top level holds the state machine, good and error counters, and output registers.

Test Plan:
- Lock acquisition: after reset, continuous frames with R0_I=00, R0_Q=01, R1_I=10, R1_Q=11 (word 8'b00011011), SYNC on bit 0.
  - LOCK rises on the edge sampling bit 0 of the 5th SYNC.
  - First VALID follows that frame's bit 7, with outputs 00/01/10/11.
  - VALID then repeats every 8 cycles.
- Steady data: alternate frames 8'b00011011 and 8'b11100100.
  - Outputs alternate 00/01/10/11 and 11/10/01/00.
  - Exactly one VALID per frame; ERR_COUNT stays 0.
- Missing SYNC while locked: drop SYNC on one frame.
  - ERR_COUNT=1 and LOCK=0 on the next cycle; no VALID for that frame.
  - Relock after 5 further good SYNCs.
- Misplaced SYNC while locked: assert SYNC at bit 3.
  - ERR_COUNT=1; state VERIFY; partial frame discarded with no VALID.
  - Relock after 4 further correct SYNCs.
- Saturation: with ERR_W=2, force 5 lock/unlock error events.
  - ERR_COUNT sticks at 3.
- Reset mid-frame: assert RST at bit 4 of a locked frame.
  - Next cycle: all outputs 0, LOCK=0, no VALID.
  - Normal reacquisition follows.
